// File: rtl/csr_pkg.sv
// ==== csr_pkg : shared CSR addresses, cause codes, bit indices and enums  (rev 1.0) ====
`default_nettype none

package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] MCAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_TMR = 32'h8000_0007;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        CSR_RW   = 2'b00,
        CSR_RS   = 2'b01,
        CSR_RC   = 2'b10,
        CSR_RSVD = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } ctrl_state_e;

    // Reserved ops fall through to RW here; the caller blocks them at the write enable.
    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_v,
                                              input logic [31:0] wd);
        case (op)
            CSR_RS:  return old_v | wd;
            CSR_RC:  return old_v & ~wd;
            default: return wd;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_if.sv
// ==== csr_if : MW-stage CSR/trap bus between pipeline (master) and csr_unit (slave)  (rev 1.0) ====
`default_nettype none

interface csr_if;
    import csr_pkg::*;

    logic [31:0] Addr;
    logic [31:0] csr_wdata;
    logic [31:0] pc_mw;
    logic        valid_mw;
    logic        csr_wr;
    logic        csr_rd;
    csr_op_e     csr_op;
    logic        is_mret;
    logic        ext_irq;
    logic        timer_irq;
    logic        Stall_MW;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc_pc;

    modport master (
        output Addr, csr_wdata, pc_mw, valid_mw, csr_wr, csr_rd, csr_op,
               is_mret, ext_irq, timer_irq, Stall_MW,
        input  csr_rdata, epc_taken, epc_pc
    );

    modport slave (
        input  Addr, csr_wdata, pc_mw, valid_mw, csr_wr, csr_rd, csr_op,
               is_mret, ext_irq, timer_irq, Stall_MW,
        output csr_rdata, epc_taken, epc_pc
    );
endinterface

`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
// ==== csr_trap_ctrl : RUN/REDIRECT controller, interrupt priority and redirect registers  (rev 1.0) ====
`default_nettype none

module csr_trap_ctrl
    import csr_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        mstatus_mie_i,
    input  wire logic        ext_pend_i,
    input  wire logic        tmr_pend_i,
    input  wire logic        valid_i,
    input  wire logic        stall_i,
    input  wire logic        is_mret_i,
    input  wire logic [31:0] mtvec_i,
    input  wire logic [31:0] mepc_i,
    output logic             trap_o,
    output logic             mret_o,
    output logic             run_o,
    output logic [31:0]      cause_o,
    output logic             epc_taken_o,
    output logic [31:0]      epc_pc_o
);

    ctrl_state_e state_q;
    logic        epc_taken_q;
    logic [31:0] epc_pc_q;
    logic [31:0] w_base;
    logic [31:0] w_target;

    assign run_o   = (state_q == ST_RUN);
    assign trap_o  = run_o & mstatus_mie_i & (ext_pend_i | tmr_pend_i) & valid_i & ~stall_i;
    assign mret_o  = run_o & is_mret_i & valid_i & ~stall_i & ~trap_o;
    assign cause_o = ext_pend_i ? MCAUSE_EXT : MCAUSE_TMR;

    // Vectored offset is 4*cause[30:0], truncated to the 32-bit address space.
    assign w_base   = {mtvec_i[31:2], 2'b00};
    assign w_target = (mtvec_i[1:0] == MTVEC_VECTORED) ? (w_base + {cause_o[29:0], 2'b00}) : w_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            epc_taken_q <= 1'b0;
            epc_pc_q    <= 32'h0;
        end else if (!stall_i) begin
            case (state_q)
                ST_RUN: begin
                    if (trap_o) begin
                        state_q     <= ST_REDIRECT;
                        epc_taken_q <= 1'b1;
                        epc_pc_q    <= w_target;
                    end else if (mret_o) begin
                        state_q     <= ST_REDIRECT;
                        epc_taken_q <= 1'b1;
                        epc_pc_q    <= mepc_i;
                    end
                end
                ST_REDIRECT: begin
                    state_q     <= ST_RUN;
                    epc_taken_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_RUN;
                    epc_taken_q <= 1'b0;
                end
            endcase
        end
    end

    assign epc_taken_o = epc_taken_q;
    assign epc_pc_o    = epc_pc_q;

endmodule

`default_nettype wire

// File: rtl/csr_unit.sv
// ==== csr_unit : machine-mode CSR file with interrupt trap entry and MRET  (rev 1.0) ====
`default_nettype none

module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  wire logic clk,
    input  wire logic rst,
    csr_if.slave      bus
);

    logic        mstatus_mie_q, mstatus_mpie_q;
    logic        mip_mtip_q, mip_meip_q;
    logic [31:0] mie_q, mtvec_q, mcause_q;
    logic [29:0] mepc_q;

    logic [11:0] w_addr;
    logic [31:0] w_old, w_wval, w_cause;
    logic        w_wr_en, w_trap, w_mret, w_run;
    logic        w_unused;

    assign w_addr   = bus.Addr[11:0];
    assign w_unused = ^{bus.Addr[31:12], bus.pc_mw[1:0]};

    always_comb begin
        w_old = 32'h0;
        case (w_addr)
            CSR_MSTATUS: begin
                w_old[MSTATUS_MIE]  = mstatus_mie_q;
                w_old[MSTATUS_MPIE] = mstatus_mpie_q;
            end
            CSR_MIE:     w_old = mie_q;
            CSR_MIP: begin
                w_old[MIP_MTIP] = mip_mtip_q;
                w_old[MIP_MEIP] = mip_meip_q;
            end
            CSR_MTVEC:   w_old = mtvec_q;
            CSR_MEPC:    w_old = {mepc_q, 2'b00};
            CSR_MCAUSE:  w_old = mcause_q;
            default:     w_old = 32'h0;
        endcase
    end

    assign bus.csr_rdata = bus.csr_rd ? w_old : 32'h0;
    assign w_wval        = csr_apply(bus.csr_op, w_old, bus.csr_wdata);
    assign w_wr_en       = bus.csr_wr & bus.valid_mw & ~bus.Stall_MW & w_run & ~w_trap
                         & (bus.csr_op != CSR_RSVD);

    // Interrupt lines are sampled every cycle, even while MW is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mip_mtip_q <= 1'b0;
            mip_meip_q <= 1'b0;
        end else begin
            mip_mtip_q <= bus.timer_irq;
            mip_meip_q <= bus.ext_irq;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= MTVEC_RST;
            mepc_q         <= 30'h0;
            mcause_q       <= 32'h0;
        end else if (w_trap) begin
            mepc_q         <= bus.pc_mw[31:2];
            mcause_q       <= w_cause;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (w_mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (w_wr_en) begin
            case (w_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_q  <= w_wval[MSTATUS_MIE];
                    mstatus_mpie_q <= w_wval[MSTATUS_MPIE];
                end
                CSR_MIE:    mie_q    <= w_wval;
                CSR_MTVEC:  mtvec_q  <= w_wval;
                CSR_MEPC:   mepc_q   <= w_wval[31:2];
                CSR_MCAUSE: mcause_q <= w_wval;
                default: ;
            endcase
        end
    end

    csr_trap_ctrl u_trap_ctrl (
        .clk           (clk),
        .rst           (rst),
        .mstatus_mie_i (mstatus_mie_q),
        .ext_pend_i    (mip_meip_q & mie_q[MIE_MEIE]),
        .tmr_pend_i    (mip_mtip_q & mie_q[MIE_MTIE]),
        .valid_i       (bus.valid_mw),
        .stall_i       (bus.Stall_MW),
        .is_mret_i     (bus.is_mret),
        .mtvec_i       (mtvec_q),
        .mepc_i        ({mepc_q, 2'b00}),
        .trap_o        (w_trap),
        .mret_o        (w_mret),
        .run_o         (w_run),
        .cause_o       (w_cause),
        .epc_taken_o   (bus.epc_taken),
        .epc_pc_o      (bus.epc_pc)
    );

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ==== tb_csr_unit : directed self-checking bench for csr_unit  (rev 1.0) ====
`default_nettype none

module tb_csr_unit;
    import csr_pkg::*;

    localparam logic [31:0] C_MTVEC_RST = 32'h8000_0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    csr_if bus ();

    csr_unit #(.MTVEC_RST(C_MTVEC_RST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
        bus.Addr   = {20'h0, a};
        bus.csr_rd = 1'b1;
        #1;
        d = bus.csr_rdata;
        bus.csr_rd = 1'b0;
    endtask

    // Upper Addr bits are set to junk to show they are ignored.
    task automatic write_csr(input logic [11:0] a, input csr_op_e op, input logic [31:0] d,
                             output logic [31:0] old_v);
        bus.Addr      = {20'hABCDE, a};
        bus.csr_op    = op;
        bus.csr_wdata = d;
        bus.csr_wr    = 1'b1;
        bus.csr_rd    = 1'b1;
        bus.valid_mw  = 1'b1;
        #1;
        old_v = bus.csr_rdata;
        tick();
        bus.csr_wr   = 1'b0;
        bus.csr_rd   = 1'b0;
        bus.valid_mw = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        read_csr(CSR_MTVEC, v);
        checks++; if (v !== C_MTVEC_RST) begin errors++; $display("FAIL rst_mtvec got %h exp %h", v, C_MTVEC_RST); end
        read_csr(CSR_MSTATUS, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mstatus got %h exp 0", v); end
        read_csr(CSR_MIE, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mie got %h exp 0", v); end
        read_csr(CSR_MEPC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h exp 0", v); end
        checks++; if (bus.epc_taken !== 1'b0) begin errors++; $display("FAIL rst_epc_taken got %b exp 0", bus.epc_taken); end
        checks++; if (bus.epc_pc !== 32'h0) begin errors++; $display("FAIL rst_epc_pc got %h exp 0", bus.epc_pc); end
        bus.Addr = {20'h0, CSR_MTVEC};
        bus.csr_rd = 1'b0;
        #1;
        checks++; if (bus.csr_rdata !== 32'h0) begin errors++; $display("FAIL rd_gated got %h exp 0", bus.csr_rdata); end
    endtask

    task automatic test_rmw();
        logic [31:0] v, o;
        write_csr(CSR_MIE, CSR_RW, 32'h880, o);
        read_csr(CSR_MIE, v);
        checks++; if (v !== 32'h880) begin errors++; $display("FAIL rw_mie got %h exp 880", v); end
        write_csr(CSR_MIE, CSR_RC, 32'h080, o);
        checks++; if (o !== 32'h880) begin errors++; $display("FAIL rc_old got %h exp 880", o); end
        read_csr(CSR_MIE, v);
        checks++; if (v !== 32'h800) begin errors++; $display("FAIL rc_mie got %h exp 800", v); end
        write_csr(CSR_MIE, CSR_RS, 32'h008, o);
        read_csr(CSR_MIE, v);
        checks++; if (v !== 32'h808) begin errors++; $display("FAIL rs_mie got %h exp 808", v); end
        write_csr(CSR_MIE, CSR_RSVD, 32'h0, o);
        read_csr(CSR_MIE, v);
        checks++; if (v !== 32'h808) begin errors++; $display("FAIL rsvd_op got %h exp 808", v); end
        write_csr(CSR_MIP, CSR_RW, 32'hFFFF_FFFF, o);
        read_csr(CSR_MIP, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mip_ro got %h exp 0", v); end
        write_csr(12'h123, CSR_RW, 32'h1234_5678, o);
        read_csr(12'h123, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL unimpl got %h exp 0", v); end
        write_csr(CSR_MEPC, CSR_RW, 32'h1234_5677, o);
        read_csr(CSR_MEPC, v);
        checks++; if (v !== 32'h1234_5674) begin errors++; $display("FAIL mepc_align got %h exp 12345674", v); end
        write_csr(CSR_MSTATUS, CSR_RW, 32'hFFFF_FFFF, o);
        read_csr(CSR_MSTATUS, v);
        checks++; if (v !== 32'h88) begin errors++; $display("FAIL mstatus_mask got %h exp 88", v); end
        write_csr(CSR_MSTATUS, CSR_RW, 32'h0, o);
    endtask

    task automatic test_ext_irq();
        logic [31:0] v, o;
        write_csr(CSR_MTVEC, CSR_RW, 32'h100, o);
        write_csr(CSR_MIE, CSR_RW, 32'h800, o);
        write_csr(CSR_MSTATUS, CSR_RW, 32'h8, o);
        bus.ext_irq  = 1'b1;
        bus.pc_mw    = 32'h40;
        bus.valid_mw = 1'b1;
        tick();
        read_csr(CSR_MIP, v);
        checks++; if (v !== 32'h800) begin errors++; $display("FAIL ext_mip got %h exp 800", v); end
        checks++; if (bus.epc_taken !== 1'b0) begin errors++; $display("FAIL ext_early got %b exp 0", bus.epc_taken); end
        tick();
        read_csr(CSR_MEPC, v);
        checks++; if (v !== 32'h40) begin errors++; $display("FAIL ext_mepc got %h exp 40", v); end
        read_csr(CSR_MCAUSE, v);
        checks++; if (v !== MCAUSE_EXT) begin errors++; $display("FAIL ext_mcause got %h exp %h", v, MCAUSE_EXT); end
        read_csr(CSR_MSTATUS, v);
        checks++; if (v !== 32'h80) begin errors++; $display("FAIL ext_mstatus got %h exp 80", v); end
        checks++; if (bus.epc_taken !== 1'b1) begin errors++; $display("FAIL ext_taken got %b exp 1", bus.epc_taken); end
        checks++; if (bus.epc_pc !== 32'h100) begin errors++; $display("FAIL ext_epc_pc got %h exp 100", bus.epc_pc); end
        bus.valid_mw = 1'b0;
        tick();
        checks++; if (bus.epc_taken !== 1'b0) begin errors++; $display("FAIL ext_pulse_len got %b exp 0", bus.epc_taken); end
        bus.ext_irq = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_vectored();
        logic [31:0] v, o;
        write_csr(CSR_MTVEC, CSR_RW, 32'h201, o);
        write_csr(CSR_MIE, CSR_RW, 32'h880, o);
        write_csr(CSR_MSTATUS, CSR_RW, 32'h8, o);
        bus.ext_irq   = 1'b1;
        bus.timer_irq = 1'b1;
        bus.pc_mw     = 32'h50;
        bus.valid_mw  = 1'b1;
        tick();
        tick();
        checks++; if (bus.epc_pc !== 32'h22C) begin errors++; $display("FAIL vec_ext_pc got %h exp 22C", bus.epc_pc); end
        read_csr(CSR_MCAUSE, v);
        checks++; if (v !== MCAUSE_EXT) begin errors++; $display("FAIL vec_prio got %h exp %h", v, MCAUSE_EXT); end
        bus.valid_mw = 1'b0;
        tick();
        write_csr(CSR_MIE, CSR_RW, 32'h080, o);
        write_csr(CSR_MSTATUS, CSR_RW, 32'h8, o);
        bus.pc_mw    = 32'h60;
        bus.valid_mw = 1'b1;
        tick();
        checks++; if (bus.epc_taken !== 1'b1) begin errors++; $display("FAIL vec_tmr_taken got %b exp 1", bus.epc_taken); end
        checks++; if (bus.epc_pc !== 32'h21C) begin errors++; $display("FAIL vec_tmr_pc got %h exp 21C", bus.epc_pc); end
        read_csr(CSR_MCAUSE, v);
        checks++; if (v !== MCAUSE_TMR) begin errors++; $display("FAIL vec_tmr_cause got %h exp %h", v, MCAUSE_TMR); end
        bus.valid_mw = 1'b0;
        tick();
        bus.ext_irq   = 1'b0;
        bus.timer_irq = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_mret();
        logic [31:0] v, o;
        write_csr(CSR_MEPC, CSR_RW, 32'h44, o);
        bus.is_mret  = 1'b1;
        bus.valid_mw = 1'b1;
        bus.pc_mw    = 32'h90;
        tick();
        checks++; if (bus.epc_taken !== 1'b1) begin errors++; $display("FAIL mret_taken got %b exp 1", bus.epc_taken); end
        checks++; if (bus.epc_pc !== 32'h44) begin errors++; $display("FAIL mret_pc got %h exp 44", bus.epc_pc); end
        read_csr(CSR_MSTATUS, v);
        checks++; if (v !== 32'h88) begin errors++; $display("FAIL mret_mstatus got %h exp 88", v); end
        bus.is_mret  = 1'b0;
        bus.valid_mw = 1'b0;
        tick();
        checks++; if (bus.epc_taken !== 1'b0) begin errors++; $display("FAIL mret_pulse_len got %b exp 0", bus.epc_taken); end
        bus.timer_irq = 1'b1;
        tick();
        tick();
        bus.is_mret  = 1'b1;
        bus.valid_mw = 1'b1;
        bus.pc_mw    = 32'h70;
        tick();
        read_csr(CSR_MEPC, v);
        checks++; if (v !== 32'h70) begin errors++; $display("FAIL mret_trap_mepc got %h exp 70", v); end
        checks++; if (bus.epc_pc !== 32'h21C) begin errors++; $display("FAIL mret_trap_pc got %h exp 21C", bus.epc_pc); end
        read_csr(CSR_MSTATUS, v);
        checks++; if (v !== 32'h80) begin errors++; $display("FAIL mret_trap_mstatus got %h exp 80", v); end
        bus.is_mret  = 1'b0;
        bus.valid_mw = 1'b0;
        tick();
        bus.timer_irq = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] v, o;
        write_csr(CSR_MTVEC, CSR_RW, 32'h100, o);
        write_csr(CSR_MSTATUS, CSR_RW, 32'h8, o);
        bus.timer_irq = 1'b1;
        tick();
        tick();
        bus.Stall_MW  = 1'b1;
        bus.valid_mw  = 1'b1;
        bus.pc_mw     = 32'h80;
        bus.csr_wr    = 1'b1;
        bus.csr_rd    = 1'b1;
        bus.Addr      = {20'h0, CSR_MSTATUS};
        bus.csr_op    = CSR_RW;
        bus.csr_wdata = 32'h0;
        bus.ext_irq   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.csr_rdata !== 32'h8) begin errors++; $display("FAIL stall_mstatus%0d got %h exp 8", i, bus.csr_rdata); end
            checks++; if (bus.epc_taken !== 1'b0) begin errors++; $display("FAIL stall_taken%0d got %b exp 0", i, bus.epc_taken); end
            if (i == 0) begin
                bus.Addr = {20'h0, CSR_MIP};
                #1;
                checks++; if (bus.csr_rdata !== 32'h880) begin errors++; $display("FAIL stall_mip got %h exp 880", bus.csr_rdata); end
                bus.Addr = {20'h0, CSR_MSTATUS};
            end
        end
        bus.Stall_MW = 1'b0;
        tick();
        bus.csr_wr   = 1'b0;
        bus.valid_mw = 1'b0;
        checks++; if (bus.epc_taken !== 1'b1) begin errors++; $display("FAIL unstall_taken got %b exp 1", bus.epc_taken); end
        checks++; if (bus.epc_pc !== 32'h100) begin errors++; $display("FAIL unstall_pc got %h exp 100", bus.epc_pc); end
        read_csr(CSR_MEPC, v);
        checks++; if (v !== 32'h80) begin errors++; $display("FAIL unstall_mepc got %h exp 80", v); end
        read_csr(CSR_MSTATUS, v);
        checks++; if (v !== 32'h80) begin errors++; $display("FAIL unstall_wr_suppressed got %h exp 80", v); end
        rst = 1'b0;
        #1;
        checks++; if (bus.epc_taken !== 1'b0) begin errors++; $display("FAIL async_rst_taken got %b exp 0", bus.epc_taken); end
        read_csr(CSR_MTVEC, v);
        checks++; if (v !== C_MTVEC_RST) begin errors++; $display("FAIL async_rst_mtvec got %h exp %h", v, C_MTVEC_RST); end
        bus.ext_irq   = 1'b0;
        bus.timer_irq = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.epc_taken !== 1'b0) begin errors++; $display("FAIL post_rst_taken got %b exp 0", bus.epc_taken); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.Addr      = 32'h0;
        bus.csr_wdata = 32'h0;
        bus.pc_mw     = 32'h0;
        bus.valid_mw  = 1'b0;
        bus.csr_wr    = 1'b0;
        bus.csr_rd    = 1'b0;
        bus.csr_op    = CSR_RW;
        bus.is_mret   = 1'b0;
        bus.ext_irq   = 1'b0;
        bus.timer_irq = 1'b0;
        bus.Stall_MW  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_rmw();
        test_ext_irq();
        test_vectored();
        test_mret();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
